// File: rtl/pipeline_flush_ctrl.sv
// Fetch-stage sequencer: drives the instruction-mux flush and PC-update controls,
// resolves trap > mret > branch redirects, and counts accepted redirects.
module pipeline_flush_ctrl #(
    parameter int unsigned FLUSH_CYCLES     = 1,
    parameter int unsigned RST_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W            = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             branch_taken_in,
    input  logic             trap_taken_in,
    input  logic             mret_in,
    input  logic             imem_ready_in,
    input  logic             stall_in,
    output logic             flush_out,
    output logic [1:0]       pc_src_out,
    output logic             pc_load_out,
    output logic             redirect_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] flush_count_out
);

    typedef enum logic [1:0] {
        RESET_FL = 2'd0,
        RUN      = 2'd1,
        FLUSH    = 2'd2,
        STALL    = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] RST_RELOAD   = 4'(RST_FLUSH_CYCLES - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [CNT_W-1:0] flush_count;
    logic             evt;
    logic             accept;
    logic [1:0]       evt_src;

    assign evt     = trap_taken_in | mret_in | branch_taken_in;
    assign evt_src = trap_taken_in ? 2'b10 : (mret_in ? 2'b11 : 2'b01);

    assign state_out       = state;
    assign flush_count_out = flush_count;

    // Outputs are decoded from the current state and inputs with no register stage.
    always_comb begin
        flush_out    = 1'b1;
        pc_load_out  = 1'b0;
        pc_src_out   = 2'b00;
        redirect_out = 1'b0;
        accept       = 1'b0;
        if (!rst_in) begin
            unique case (state)
                RESET_FL: ;
                RUN: begin
                    if (evt) begin
                        accept = 1'b1;
                    end else if (stall_in) begin
                        flush_out = 1'b0;
                    end else if (imem_ready_in) begin
                        pc_load_out = 1'b1;
                        flush_out   = 1'b0;
                    end
                end
                FLUSH: accept = trap_taken_in;
                STALL: begin
                    flush_out = 1'b0;
                    accept    = trap_taken_in;
                end
                default: ;
            endcase
            if (accept) begin
                pc_src_out   = evt_src;
                pc_load_out  = 1'b1;
                flush_out    = 1'b1;
                redirect_out = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= RESET_FL;
            cnt         <= RST_RELOAD;
            flush_count <= '0;
        end else begin
            if (accept && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
            unique case (state)
                RESET_FL: begin
                    if (cnt == 4'd0) state <= RUN;
                    else             cnt   <= cnt - 4'd1;
                end
                RUN: begin
                    if (evt) begin
                        cnt   <= FLUSH_RELOAD;
                        state <= FLUSH;
                    end else if (stall_in) begin
                        state <= STALL;
                    end
                end
                FLUSH: begin
                    // The counter parks at zero until the fetch side delivers a word.
                    if (trap_taken_in)                     cnt   <= FLUSH_RELOAD;
                    else if (cnt == 4'd0 && imem_ready_in) state <= RUN;
                    else if (cnt != 4'd0)                  cnt   <= cnt - 4'd1;
                end
                STALL: begin
                    if (trap_taken_in) begin
                        cnt   <= FLUSH_RELOAD;
                        state <= FLUSH;
                    end else if (!stall_in) begin
                        state <= RUN;
                    end
                end
                default: state <= RESET_FL;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Scoreboard bench for pipeline_flush_ctrl: a default instance and a narrow-counter,
// longer-flush instance share stimulus; a reference model predicts every output.
module tb_pipeline_flush_ctrl;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_in, branch_taken_in, trap_taken_in, mret_in, imem_ready_in, stall_in;

    logic        a_flush, a_load, a_red;
    logic [1:0]  a_src, a_state;
    logic [15:0] a_count;
    logic        b_flush, b_load, b_red;
    logic [1:0]  b_src, b_state;
    logic [1:0]  b_count;

    pipeline_flush_ctrl dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .branch_taken_in(branch_taken_in),
        .trap_taken_in(trap_taken_in), .mret_in(mret_in), .imem_ready_in(imem_ready_in),
        .stall_in(stall_in), .flush_out(a_flush), .pc_src_out(a_src), .pc_load_out(a_load),
        .redirect_out(a_red), .state_out(a_state), .flush_count_out(a_count)
    );

    pipeline_flush_ctrl #(.FLUSH_CYCLES(3), .RST_FLUSH_CYCLES(4), .CNT_W(2)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .branch_taken_in(branch_taken_in),
        .trap_taken_in(trap_taken_in), .mret_in(mret_in), .imem_ready_in(imem_ready_in),
        .stall_in(stall_in), .flush_out(b_flush), .pc_src_out(b_src), .pc_load_out(b_load),
        .redirect_out(b_red), .state_out(b_state), .flush_count_out(b_count)
    );

    typedef struct {
        logic        flush;
        logic        load;
        logic [1:0]  src;
        logic        red;
        logic [1:0]  st;
        int unsigned cnt;
    } exp_t;

    exp_t        sb[$];
    int unsigned m_state[2];
    int unsigned m_cnt[2];
    int unsigned m_fc[2];
    int unsigned fl_cyc[2]  = '{1, 3};
    int unsigned rst_cyc[2] = '{2, 4};
    int unsigned sat[2]     = '{65535, 3};
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            m_state[k] = 0;
            m_cnt[k]   = rst_cyc[k] - 1;
            m_fc[k]    = 0;
        end
    endtask

    // One clock cycle: drive, predict, compare at the falling edge, then advance the model.
    task automatic cyc(input logic r, input logic tr, input logic mr, input logic br,
                       input logic rdy, input logic st);
        int unsigned ns[2], nc[2], nf[2];
        exp_t e;
        rst_in = r; trap_taken_in = tr; mret_in = mr; branch_taken_in = br;
        imem_ready_in = rdy; stall_in = st;
        for (int unsigned k = 0; k < 2; k++) begin
            logic acc;
            acc     = 1'b0;
            e.flush = 1'b1; e.load = 1'b0; e.src = 2'b00; e.red = 1'b0;
            e.st    = 2'(m_state[k]);
            e.cnt   = m_fc[k];
            ns[k] = m_state[k]; nc[k] = m_cnt[k]; nf[k] = m_fc[k];
            if (!r) begin
                case (m_state[k])
                    1: if (tr || mr || br) acc = 1'b1;
                       else if (st) e.flush = 1'b0;
                       else if (rdy) begin e.load = 1'b1; e.flush = 1'b0; end
                    2: acc = tr;
                    3: begin e.flush = 1'b0; acc = tr; end
                    default: ;
                endcase
                if (acc) begin
                    e.flush = 1'b1; e.load = 1'b1; e.red = 1'b1;
                    e.src = tr ? 2'b10 : (mr ? 2'b11 : 2'b01);
                    if (nf[k] < sat[k]) nf[k]++;
                end
                case (m_state[k])
                    0: if (m_cnt[k] == 0) ns[k] = 1; else nc[k] = m_cnt[k] - 1;
                    1: if (acc) begin ns[k] = 2; nc[k] = fl_cyc[k] - 1; end
                       else if (st) ns[k] = 3;
                    2: if (tr) nc[k] = fl_cyc[k] - 1;
                       else if (m_cnt[k] == 0) begin if (rdy) ns[k] = 1; end
                       else nc[k] = m_cnt[k] - 1;
                    default: if (tr) begin ns[k] = 2; nc[k] = fl_cyc[k] - 1; end
                             else if (!st) ns[k] = 1;
                endcase
            end else begin
                ns[k] = 0; nc[k] = rst_cyc[k] - 1; nf[k] = 0;
            end
            sb.push_back(e);
        end
        @(negedge clk_in);
        e = sb.pop_front();
        check_eq("a.flush", 32'(a_flush), 32'(e.flush));
        check_eq("a.load",  32'(a_load),  32'(e.load));
        check_eq("a.src",   32'(a_src),   32'(e.src));
        check_eq("a.redir", 32'(a_red),   32'(e.red));
        check_eq("a.state", 32'(a_state), 32'(e.st));
        check_eq("a.count", 32'(a_count), e.cnt);
        e = sb.pop_front();
        check_eq("b.flush", 32'(b_flush), 32'(e.flush));
        check_eq("b.load",  32'(b_load),  32'(e.load));
        check_eq("b.src",   32'(b_src),   32'(e.src));
        check_eq("b.redir", 32'(b_red),   32'(e.red));
        check_eq("b.state", 32'(b_state), 32'(e.st));
        check_eq("b.count", 32'(b_count), e.cnt);
        for (int unsigned k = 0; k < 2; k++) begin
            m_state[k] = ns[k]; m_cnt[k] = nc[k]; m_fc[k] = nf[k];
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cyc(0, 0, 0, 0, 1, 0);
    endtask

    int unsigned sat_want[5] = '{1, 2, 3, 3, 3};

    initial begin
        rst_in = 1'b1; trap_taken_in = 1'b0; mret_in = 1'b0; branch_taken_in = 1'b0;
        imem_ready_in = 1'b1; stall_in = 1'b0;
        @(posedge clk_in);
        #1;
        model_reset();

        // Reset release and forced flush window
        cyc(1, 0, 0, 0, 1, 0);
        idle(6);
        check_eq("rst.a_count", 32'(a_count), 32'd0);
        // Branch redirect from RUN
        cyc(0, 0, 0, 1, 1, 0);
        idle(6);
        check_eq("br.a_count", 32'(a_count), 32'd1);
        // Simultaneous trap/mret/branch counts once
        cyc(0, 1, 1, 1, 1, 0);
        idle(6);
        check_eq("pri.a_count", 32'(a_count), 32'd2);
        // Mret alone, then a fetch miss bubble
        cyc(0, 0, 1, 0, 1, 0);
        idle(6);
        cyc(0, 0, 0, 0, 0, 0);
        // Stall, then trap while stalled
        for (int unsigned i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 1, 1, 1);
        cyc(0, 1, 0, 0, 1, 1);
        idle(6);
        // FLUSH with memory not ready; wrong-path events ignored, trap accepted
        cyc(0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check_eq("rstfl.a_state", 32'(a_state), 32'd0);
        check_eq("rstfl.a_count", 32'(a_count), 32'd0);
        idle(6);
        // Saturation of the narrow counter
        for (int unsigned i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1, 1, 0);
            check_eq("sat.b_count", 32'(b_count), sat_want[i]);
            idle(6);
        end
        // Random traffic
        for (int unsigned i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
